threshold_window_axi_reader: RTL and testbench
==============================================

// Module: threshold_window_axi_reader
// PURPOSE
// AXI4 read initiator for the ThresholdCutter window RAM (responder side exposes s_axi_ar*/s_axi_r*).
// Accepts a window-index request, waits for RAM reset-busy to clear, issues one INCR burst and
// streams the returned WINDOW_WIDTH-bit beats downstream with valid/ready/last framing.
// Sits between ThresholdCutter's AXI RAM port and the window consumer (PS bridge / classifier).
// PARAMETERS
// WINDOW_DEPTH_INDEX  7        width of window index (up to 128 windows)
// WINDOW_DEPTH        100      number of valid windows; index >= this is rejected
// WINDOW_WIDTH        256      AXI data width in bits (32B beat)
// BLOCK_NUM_INDEX     4        log2(beats per window); 16 beats
// AXI_ID              4'h0     ARID driven; RID checked against it
// BASE_ADDR           32'h0    byte address of window 0
// PORTS
// clk            in   1                    system clock
// rst_n          in   1                    async active-low reset
// req_valid      in   1                    window read request
// req_ready      out  1                    request accepted when valid&&ready
// req_win        in   WINDOW_DEPTH_INDEX   window index to read
// rsta_busy      in   1                    RAM port A reset-busy
// rstb_busy      in   1                    RAM port B reset-busy
// m_axi_arid     out  4                    = AXI_ID
// m_axi_araddr   out  32                   BASE_ADDR + (win << (BLOCK_NUM_INDEX+5))
// m_axi_arlen    out  8                    2**BLOCK_NUM_INDEX-1
// m_axi_arsize   out  3                    3'b101 (32B)
// m_axi_arburst  out  2                    2'b01 INCR
// m_axi_arvalid  out  1                    address valid
// m_axi_arready  in   1                    address ready
// m_axi_rid/rdata/rresp/rlast/rvalid in 4/WINDOW_WIDTH/2/1/1  read data channel
// m_axi_rready   out  1                    read data ready
// out_data       out  WINDOW_WIDTH         beat data (= rdata)
// out_valid      out  1                    beat valid
// out_ready      in   1                    downstream ready
// out_last       out  1                    final beat of window
// out_win        out  WINDOW_DEPTH_INDEX   index of window being streamed
// busy_o         out  1                    state != IDLE
// err_resp_o     out  1                    sticky: rresp!=0, rid!=AXI_ID, or rlast on wrong beat
// err_range_o    out  1                    1-cycle pulse: rejected out-of-range request
// BEHAVIOUR
// Reset values: req_ready 0 in reset, 1 first cycle after; arvalid/rready/out_valid/out_last 0;
//   araddr 0; out_win 0; busy_o 0; err_resp_o 0; err_range_o 0; beat counter 0; state IDLE.
// FSM IDLE -> WAIT_RAM -> ADDR -> DATA -> IDLE.
// IDLE: req_ready=1. On req_valid: latch req_win into out_win, clear err_resp_o.
//   win >= WINDOW_DEPTH: stay IDLE, err_range_o=1 next cycle only, no AR issued.
//   else -> WAIT_RAM.
// WAIT_RAM: when rsta_busy==0 && rstb_busy==0 -> ADDR; arvalid registered high on entry.
// ADDR: AR fields and arvalid held stable until arready; handshake cycle -> DATA, arvalid 0 next.
// DATA: zero-latency pass-through: out_valid=rvalid, out_data=rdata, rready=out_ready.
//   Beat counter (BLOCK_NUM_INDEX bits) increments on rvalid&&rready.
//   out_last = (counter == 2**BLOCK_NUM_INDEX-1) && out_valid; framing uses counter, not rlast.
//   rlast mismatch vs counter, rresp!=0, or rid!=AXI_ID on a handshaked beat -> err_resp_o set;
//   burst still completes all beats.
//   Last-beat handshake -> IDLE, counter 0; req_ready high next cycle (no back-to-back overlap).
// out_ready low: rready low, beat held by responder; no beat dropped/duplicated.
// rvalid outside DATA ignored (rready 0).
// Async reset mid-burst: immediate return to reset values; responder shares rst_n so no
//   outstanding burst survives.
// TESTING
// 1) req_win=3, busy low, arready=1 -> araddr 0x600, arlen 15, arsize 5, arburst 1; 16 beats out, out_last on 16th only.
// 2) out_ready toggled 1/0 each cycle over burst -> rready mirrors, 16 beats in order, out_last once.
// 3) req_win=100 -> no arvalid, err_range_o 1 cycle, req_ready 1 again, busy_o stays 0.
// 4) rsta_busy high 20 cycles after request -> arvalid 0 throughout; arvalid 1 cycle after busy drops.
// 5) rresp=2'b10 on beat 5 -> err_resp_o set and held; all 16 beats delivered; cleared on next accept.
// 6) rst_n low during beat 7 -> all outputs to reset values at once; next req_win=0 gives araddr 0x000, full burst.

Source files
------------

// File: rtl/threshold_window_axi_reader.sv
// AXI4 read initiator for the ThresholdCutter window RAM: one INCR burst per accepted
// window index, streamed downstream with valid/ready/last framing.
module threshold_window_axi_reader #(
  parameter int          WINDOW_DEPTH_INDEX = 7,
  parameter int          WINDOW_DEPTH       = 100,
  parameter int          WINDOW_WIDTH       = 256,
  parameter int          BLOCK_NUM_INDEX    = 4,
  parameter logic [3:0]  AXI_ID             = 4'h0,
  parameter logic [31:0] BASE_ADDR          = 32'h0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [WINDOW_DEPTH_INDEX-1:0] req_win,
  input  logic                          rsta_busy,
  input  logic                          rstb_busy,
  output logic [3:0]                    m_axi_arid,
  output logic [31:0]                   m_axi_araddr,
  output logic [7:0]                    m_axi_arlen,
  output logic [2:0]                    m_axi_arsize,
  output logic [1:0]                    m_axi_arburst,
  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,
  input  logic [3:0]                    m_axi_rid,
  input  logic [WINDOW_WIDTH-1:0]       m_axi_rdata,
  input  logic [1:0]                    m_axi_rresp,
  input  logic                          m_axi_rlast,
  input  logic                          m_axi_rvalid,
  output logic                          m_axi_rready,
  output logic [WINDOW_WIDTH-1:0]       out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_last,
  output logic [WINDOW_DEPTH_INDEX-1:0] out_win,
  output logic                          busy_o,
  output logic                          err_resp_o,
  output logic                          err_range_o
);

  localparam int                         ADDR_SHIFT = BLOCK_NUM_INDEX + 5;
  localparam logic [31:0]                DEPTH_L    = 32'(WINDOW_DEPTH);
  localparam logic [7:0]                 ARLEN_L    = 8'((1 << BLOCK_NUM_INDEX) - 1);
  localparam logic [BLOCK_NUM_INDEX-1:0] LAST_BEAT  = '1;
  localparam logic [BLOCK_NUM_INDEX-1:0] CNT_ONE    = BLOCK_NUM_INDEX'(1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_RAM = 2'd1,
    ADDR     = 2'd2,
    DATA     = 2'd3
  } state_e;

  state_e                          state_q, state_d;
  logic                            req_ready_q, req_ready_d;
  logic                            arvalid_q, arvalid_d;
  logic [31:0]                     araddr_q, araddr_d;
  logic [WINDOW_DEPTH_INDEX-1:0]   out_win_q, out_win_d;
  logic                            busy_q, busy_d;
  logic                            err_resp_q, err_resp_d;
  logic                            err_range_q, err_range_d;
  logic [BLOCK_NUM_INDEX-1:0]      cnt_q, cnt_d;

  logic                            in_data_s;
  logic                            beat_hs_s;
  logic                            at_last_s;
  logic                            beat_bad_s;
  logic [31:0]                     req_win_ext_s;

  assign in_data_s     = (state_q == DATA);
  assign beat_hs_s     = in_data_s && m_axi_rvalid && out_ready;
  assign at_last_s     = (cnt_q == LAST_BEAT);
  assign req_win_ext_s = 32'(req_win);
  assign beat_bad_s    = (m_axi_rresp != 2'b00) || (m_axi_rid != AXI_ID) ||
                         (m_axi_rlast != at_last_s);

  // Data channel is a zero-latency pass-through; framing comes from the beat counter.
  assign out_data      = m_axi_rdata;
  assign out_valid     = in_data_s && m_axi_rvalid;
  assign m_axi_rready  = in_data_s && out_ready;
  assign out_last      = at_last_s && out_valid;

  assign m_axi_arid    = AXI_ID;
  assign m_axi_arlen   = ARLEN_L;
  assign m_axi_arsize  = 3'b101;
  assign m_axi_arburst = 2'b01;
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arvalid = arvalid_q;
  assign req_ready     = req_ready_q;
  assign out_win       = out_win_q;
  assign busy_o        = busy_q;
  assign err_resp_o    = err_resp_q;
  assign err_range_o   = err_range_q;

  // Next-state and next-output computation for the read FSM.
  always_comb begin
    state_d     = state_q;
    arvalid_d   = arvalid_q;
    araddr_d    = araddr_q;
    out_win_d   = out_win_q;
    err_resp_d  = err_resp_q;
    err_range_d = 1'b0;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          out_win_d  = req_win;
          err_resp_d = 1'b0;
          if (req_win_ext_s >= DEPTH_L) begin
            err_range_d = 1'b1;
          end else begin
            araddr_d = BASE_ADDR + (req_win_ext_s << ADDR_SHIFT);
            state_d  = WAIT_RAM;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_RAM: begin
        if (!rsta_busy && !rstb_busy) begin
          state_d   = ADDR;
          arvalid_d = 1'b1;
        end else begin
          state_d = WAIT_RAM;
        end
      end
      ADDR: begin
        if (m_axi_arready) begin
          state_d   = DATA;
          arvalid_d = 1'b0;
        end else begin
          state_d = ADDR;
        end
      end
      DATA: begin
        if (beat_hs_s) begin
          if (beat_bad_s) begin
            err_resp_d = 1'b1;
          end else begin
            err_resp_d = err_resp_q;
          end
          if (at_last_s) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else begin
          state_d = DATA;
        end
      end
      default: begin
        state_d   = IDLE;
        arvalid_d = 1'b0;
        cnt_d     = '0;
      end
    endcase
    req_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  // State and registered-output flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b0;
      arvalid_q   <= 1'b0;
      araddr_q    <= 32'h0;
      out_win_q   <= '0;
      busy_q      <= 1'b0;
      err_resp_q  <= 1'b0;
      err_range_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      arvalid_q   <= arvalid_d;
      araddr_q    <= araddr_d;
      out_win_q   <= out_win_d;
      busy_q      <= busy_d;
      err_resp_q  <= err_resp_d;
      err_range_q <= err_range_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_threshold_window_axi_reader.sv
// Directed self-checking bench for threshold_window_axi_reader; the bench plays the AXI
// responder and the downstream consumer.
module tb_threshold_window_axi_reader;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid;
  logic         req_ready;
  logic [6:0]   req_win;
  logic         rsta_busy, rstb_busy;
  logic [3:0]   m_axi_arid;
  logic [31:0]  m_axi_araddr;
  logic [7:0]   m_axi_arlen;
  logic [2:0]   m_axi_arsize;
  logic [1:0]   m_axi_arburst;
  logic         m_axi_arvalid, m_axi_arready;
  logic [3:0]   m_axi_rid;
  logic [255:0] m_axi_rdata;
  logic [1:0]   m_axi_rresp;
  logic         m_axi_rlast, m_axi_rvalid, m_axi_rready;
  logic [255:0] out_data;
  logic         out_valid, out_ready, out_last;
  logic [6:0]   out_win;
  logic         busy_o, err_resp_o, err_range_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  threshold_window_axi_reader dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_win(req_win),
    .rsta_busy(rsta_busy), .rstb_busy(rstb_busy),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .out_win(out_win), .busy_o(busy_o), .err_resp_o(err_resp_o), .err_range_o(err_range_o)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] pat(input logic [6:0] w, input int b);
    pat = {8{w, 1'b0, 8'hC3, 16'(b)}};
  endfunction

  task automatic reset_checks(input string tag);
    check({tag, "_req_ready"}, req_ready, 0);
    check({tag, "_arvalid"}, m_axi_arvalid, 0);
    check({tag, "_rready"}, m_axi_rready, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_last"}, out_last, 0);
    check({tag, "_araddr"}, m_axi_araddr, 0);
    check({tag, "_out_win"}, out_win, 0);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_err_resp"}, err_resp_o, 0);
    check({tag, "_err_range"}, err_range_o, 0);
  endtask

  task automatic request(input logic [6:0] w);
    @(negedge clk);
    req_valid = 1'b1;
    req_win   = w;
    #1;
    check("req_ready", req_ready, 1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    check("err_resp_clear", err_resp_o, 0);
    check("out_win", out_win, w);
  endtask

  task automatic addr_phase(input logic [31:0] exp_addr, input string tag);
    int  waited = 0;
    bit  found  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      if (m_axi_arvalid) begin
        found = 1'b1;
        break;
      end
      waited++;
    end
    check({tag, "_arvalid_seen"}, found, 1);
    check({tag, "_ar_latency"}, waited, 0);
    check({tag, "_araddr"}, m_axi_araddr, exp_addr);
    check({tag, "_arlen"}, m_axi_arlen, 15);
    check({tag, "_arsize"}, m_axi_arsize, 5);
    check({tag, "_arburst"}, m_axi_arburst, 1);
    check({tag, "_arid"}, m_axi_arid, 0);
    check({tag, "_busy"}, busy_o, 1);
    check({tag, "_req_ready_low"}, req_ready, 0);
    // Hold AR for one extra cycle to confirm it stays stable without arready.
    @(negedge clk);
    #1;
    check({tag, "_arvalid_hold"}, m_axi_arvalid, 1);
    check({tag, "_araddr_hold"}, m_axi_araddr, exp_addr);
    m_axi_arready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    m_axi_arready = 1'b0;
    #1;
    check({tag, "_arvalid_drop"}, m_axi_arvalid, 0);
  endtask

  task automatic data_phase(input logic [6:0] w, input bit toggle, input int err_beat,
                            input int abort_beat, input string tag);
    int beat    = 0;
    int lasts   = 0;
    int cyc     = 0;
    bit aborted = 1'b0;
    while (beat < 16 && cyc < 100) begin
      @(negedge clk);
      m_axi_rvalid = 1'b1;
      m_axi_rdata  = pat(w, beat);
      m_axi_rid    = 4'h0;
      m_axi_rresp  = (beat == err_beat) ? 2'b10 : 2'b00;
      m_axi_rlast  = (beat == 15);
      out_ready    = toggle ? (cyc % 2 == 0) : 1'b1;
      #1;
      if (beat == abort_beat) begin
        rst_n = 1'b0;
        #1;
        reset_checks({tag, "_abort"});
        aborted = 1'b1;
        break;
      end
      check({tag, "_rready"}, m_axi_rready, out_ready);
      check({tag, "_out_valid"}, out_valid, 1);
      check({tag, "_out_data"}, out_data, pat(w, beat));
      check({tag, "_out_last"}, out_last, beat == 15);
      if (err_beat >= 0 && beat > err_beat) check({tag, "_err_held"}, err_resp_o, 1);
      if (out_ready) begin
        if (out_last) lasts++;
        beat++;
      end
      cyc++;
    end
    if (aborted) begin
      m_axi_rvalid = 1'b0;
      m_axi_rlast  = 1'b0;
      out_ready    = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
    end else begin
      @(negedge clk);
      m_axi_rvalid = 1'b0;
      m_axi_rlast  = 1'b0;
      m_axi_rresp  = 2'b00;
      out_ready    = 1'b1;
      #1;
      check({tag, "_beats"}, beat, 16);
      check({tag, "_last_count"}, lasts, 1);
      check({tag, "_busy_end"}, busy_o, 0);
      check({tag, "_req_ready_end"}, req_ready, 1);
      check({tag, "_out_valid_end"}, out_valid, 0);
      check({tag, "_err_resp_end"}, err_resp_o, err_beat >= 0);
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    req_valid     = 1'b0;
    req_win       = 7'd0;
    rsta_busy     = 1'b0;
    rstb_busy     = 1'b0;
    m_axi_arready = 1'b0;
    m_axi_rid     = 4'h0;
    m_axi_rdata   = 256'h0;
    m_axi_rresp   = 2'b00;
    m_axi_rlast   = 1'b0;
    m_axi_rvalid  = 1'b0;
    out_ready     = 1'b1;

    #12;
    reset_checks("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("rst_req_ready_after", req_ready, 1);
    check("rst_busy_after", busy_o, 0);

    // 1) basic burst, window 3
    request(7'd3);
    addr_phase(32'h600, "t1");
    data_phase(7'd3, 1'b0, -1, -1, "t1");

    // 2) out_ready toggling every cycle
    request(7'd5);
    addr_phase(32'hA00, "t2");
    data_phase(7'd5, 1'b1, -1, -1, "t2");

    // 3) out-of-range window
    request(7'd100);
    check("t3_err_range", err_range_o, 1);
    check("t3_arvalid", m_axi_arvalid, 0);
    check("t3_busy", busy_o, 0);
    check("t3_req_ready", req_ready, 1);
    @(negedge clk);
    #1;
    check("t3_err_range_pulse", err_range_o, 0);
    check("t3_arvalid_after", m_axi_arvalid, 0);
    check("t3_busy_after", busy_o, 0);

    // 4) RAM reset-busy held for 20 cycles
    rsta_busy = 1'b1;
    rstb_busy = 1'b1;
    request(7'd7);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      check("t4_arvalid_busy", m_axi_arvalid, 0);
      if (i == 9) rstb_busy = 1'b0;
    end
    rsta_busy = 1'b0;
    addr_phase(32'hE00, "t4");
    data_phase(7'd7, 1'b0, -1, -1, "t4");

    // 5) SLVERR on beat 5, then cleared by next accept
    request(7'd9);
    addr_phase(32'h1200, "t5");
    data_phase(7'd9, 1'b0, 5, -1, "t5");
    request(7'd2);
    addr_phase(32'h400, "t5b");
    data_phase(7'd2, 1'b0, -1, -1, "t5b");

    // 6) async reset mid-burst, then a clean window-0 read
    request(7'd4);
    addr_phase(32'h800, "t6");
    data_phase(7'd4, 1'b0, -1, 7, "t6");
    @(negedge clk);
    #1;
    check("t6_req_ready_after", req_ready, 1);
    request(7'd0);
    addr_phase(32'h000, "t6b");
    data_phase(7'd0, 1'b0, -1, -1, "t6b");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
